scan_mux: RTL

SCAN_MUX -- requirements
Module: scan_mux

---
 rtl/scan_mux.sv | 105 ++++++++++
 1 files changed

// File: rtl/scan_mux.sv
// Registered channel multiplexer with static select and round-robin scan modes.
// One output slot with valid/ready handshake; a capture happens when en is high and the slot is free.
module scan_mux #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      en,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      sel_err
);

    // Wrap at the last real channel; an out-of-range index also restarts at 0.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] v);
        if (v >= SEL_W'(CHANNELS - 1)) begin
            return '0;
        end
        return v + SEL_W'(1);
    endfunction

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             sel_err_q, sel_err_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             mode_prev_q, mode_prev_d;

    logic             capture;
    logic             scan_entry;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] data_sel;
    logic             in_range;

    always_comb begin
        capture    = en && (!out_valid_q || out_ready);
        scan_entry = mode && !mode_prev_q;
        // The first scan capture starts at sel, not at the stale pointer.
        idx        = (mode && !scan_entry) ? ptr_q : sel;

        data_sel = '0;
        in_range = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                data_sel = in[k*WIDTH +: WIDTH];
                in_range = 1'b1;
            end
        end

        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        sel_err_d   = sel_err_q;
        ptr_d       = ptr_q;
        mode_prev_d = mode;

        if (capture) begin
            out_d       = in_range ? data_sel : '0;
            out_valid_d = 1'b1;
            out_ch_d    = idx;
            sel_err_d   = !in_range;
            if (mode) begin
                ptr_d = next_ch(idx);
            end
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (scan_entry) begin
                ptr_d = sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            sel_err_q   <= 1'b0;
            ptr_q       <= '0;
            mode_prev_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            sel_err_q   <= sel_err_d;
            ptr_q       <= ptr_d;
            mode_prev_q <= mode_prev_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign sel_err   = sel_err_q;

endmodule
